// File: rtl/shape_pkg.sv
// Shared definitions for the shape record writer and reader: word layout, FSM states, record length.
package shape_pkg;

    localparam int unsigned SHAPE_DATAB    = 3;
    localparam int unsigned SHAPE_W_TYPE   = 0;
    localparam int unsigned SHAPE_W_X      = 1;
    localparam int unsigned SHAPE_W_Y      = 2;
    localparam int unsigned SHAPE_W_SIZE   = 3;
    localparam int unsigned SHAPE_W_ROTATE = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } shape_state_e;

    // Words per record for a given log2 record length.
    function automatic int unsigned rec_words(input int unsigned datab);
        return 32'(1) << datab;
    endfunction

endpackage

// File: rtl/shape_write_if.sv
// Shape descriptor request and shape RAM write port bundle.
// Optional macro SHAPE_WRITE_ERASE_EN adds the erase request bit.
interface shape_write_if #(
    parameter int unsigned CORDW = 10,
    parameter int unsigned ADDRW = 20,
    parameter int unsigned DATAW = 12,
    parameter int unsigned NUMW  = DATAW
);
    logic [NUMW-1:0]  id;
    logic             trigger;
    logic [DATAW-1:0] ty;
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic [DATAW-1:0] size;
    logic [DATAW-1:0] rotate;
    logic [ADDRW-1:0] ram_address_offset;
`ifdef SHAPE_WRITE_ERASE_EN
    logic             erase;
`endif
    logic [ADDRW-1:0] ram_address;
    logic             ram_we;
    logic [DATAW-1:0] ram_data;
    logic             busy;
    logic             done;

    modport slave (
        input  id, trigger, ty, x, y, size, rotate, ram_address_offset,
`ifdef SHAPE_WRITE_ERASE_EN
        input  erase,
`endif
        output ram_address, ram_we, ram_data, busy, done
    );

    modport master (
        output id, trigger, ty, x, y, size, rotate, ram_address_offset,
`ifdef SHAPE_WRITE_ERASE_EN
        output erase,
`endif
        input  ram_address, ram_we, ram_data, busy, done
    );

endinterface

// File: rtl/shape_write.sv
// Writes one latched shape descriptor into the shape RAM as a record of 2^DATAB words.
// Optional macro SHAPE_WRITE_ERASE_EN: erase request writes an all-zero record.
module shape_write
    import shape_pkg::*;
#(
    parameter int unsigned DATAB = SHAPE_DATAB,
    parameter int unsigned CORDW = 10,
    parameter int unsigned ADDRW = 20,
    parameter int unsigned DATAW = 12,
    parameter int unsigned NUMW  = DATAW
) (
    input  logic         clk,
    input  logic         rst_n,
    shape_write_if.slave bus
);

    localparam int unsigned     REC_WORDS = rec_words(DATAB);
    localparam logic [DATAB-1:0] LAST_PTR = DATAB'(REC_WORDS - 1);

    shape_state_e     r_state;
    logic [DATAB-1:0] r_ptr;
    logic [ADDRW-1:0] r_base;
    logic [DATAW-1:0] r_ty;
    logic [CORDW-1:0] r_x;
    logic [CORDW-1:0] r_y;
    logic [DATAW-1:0] r_size;
    logic [DATAW-1:0] r_rotate;
    logic             r_erase;
    logic [ADDRW-1:0] r_addr;
    logic [DATAW-1:0] r_data;
    logic             r_we;
    logic             r_busy;
    logic             r_done;

    logic             w_erase;
    logic [ADDRW-1:0] w_start_base;
    logic [DATAB-1:0] w_next_ptr;
    logic [ADDRW-1:0] w_next_addr;
    logic [DATAW-1:0] w_first_data;
    logic [DATAW-1:0] w_next_data;

    // Record word layout; padding words and erased records are zero.
    function automatic logic [DATAW-1:0] word_sel(
        input logic [DATAB-1:0] ptr,
        input logic [DATAW-1:0] ty,
        input logic [CORDW-1:0] x,
        input logic [CORDW-1:0] y,
        input logic [DATAW-1:0] size,
        input logic [DATAW-1:0] rotate,
        input logic             blank
    );
        logic [DATAW-1:0] w;
        w = '0;
        if (!blank) begin
            case (ptr)
                DATAB'(SHAPE_W_TYPE):   w = ty;
                DATAB'(SHAPE_W_X):      w = DATAW'(x);
                DATAB'(SHAPE_W_Y):      w = DATAW'(y);
                DATAB'(SHAPE_W_SIZE):   w = size;
                DATAB'(SHAPE_W_ROTATE): w = rotate;
                default:                w = '0;
            endcase
        end
        return w;
    endfunction

`ifdef SHAPE_WRITE_ERASE_EN
    assign w_erase = bus.erase;
`else
    assign w_erase = 1'b0;
`endif

    assign w_start_base = ADDRW'(ADDRW'(bus.id) << DATAB) + bus.ram_address_offset;
    assign w_next_ptr   = r_ptr + DATAB'(1);
    assign w_next_addr  = r_base + ADDRW'(w_next_ptr);
    assign w_first_data = word_sel(DATAB'(0), bus.ty, bus.x, bus.y, bus.size, bus.rotate, w_erase);
    assign w_next_data  = word_sel(w_next_ptr, r_ty, r_x, r_y, r_size, r_rotate, r_erase);

    // Record sequencer: the first word goes out on the cycle right after the trigger edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_base   <= '0;
            r_ty     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_size   <= '0;
            r_rotate <= '0;
            r_erase  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.trigger) begin
                        r_state  <= ST_WRITE;
                        r_ptr    <= '0;
                        r_base   <= w_start_base;
                        r_ty     <= bus.ty;
                        r_x      <= bus.x;
                        r_y      <= bus.y;
                        r_size   <= bus.size;
                        r_rotate <= bus.rotate;
                        r_erase  <= w_erase;
                        r_addr   <= w_start_base;
                        r_data   <= w_first_data;
                        r_we     <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (r_ptr == LAST_PTR) begin
                        r_state <= ST_IDLE;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr  <= w_next_ptr;
                        r_addr <= w_next_addr;
                        r_data <= w_next_data;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_address = r_addr;
    assign bus.ram_we      = r_we;
    assign bus.ram_data    = r_data;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_shape_write.sv
// Bench for shape_write: record-level reference model, directed scenarios and random records.
module tb_shape_write;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shape_write_if #(.CORDW(10), .ADDRW(20), .DATAW(12), .NUMW(12)) bus ();

    shape_write #(.DATAB(3), .CORDW(10), .ADDRW(20), .DATAW(12), .NUMW(12)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a record is a list of 8 words placed at (id*8+offset+i) mod 2^20.
    logic [19:0] m_base = '0;
    logic [11:0] m_words [8];
    int          m_idx  = -1;
    logic        e_we   = 1'b0;
    logic        e_done = 1'b0;
    logic [19:0] e_addr = '0;
    logic [11:0] e_data = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_idx = -1; e_we = 1'b0; e_done = 1'b0; e_addr = '0; e_data = '0;
            end else begin
                e_done = 1'b0;
                if (m_idx < 0) begin
                    if (bus.trigger === 1'b1) begin
                        bit blank;
                        blank = 1'b0;
`ifdef SHAPE_WRITE_ERASE_EN
                        blank = bus.erase;
`endif
                        m_base = 20'(32'(bus.id) * 8 + 32'(bus.ram_address_offset));
                        for (int i = 0; i < 8; i++) m_words[i] = '0;
                        if (!blank) begin
                            m_words[0] = bus.ty;
                            m_words[1] = 12'(bus.x);
                            m_words[2] = 12'(bus.y);
                            m_words[3] = bus.size;
                            m_words[4] = bus.rotate;
                        end
                        m_idx = 0; e_we = 1'b1; e_addr = m_base; e_data = m_words[0];
                    end
                end else if (m_idx == 7) begin
                    m_idx = -1; e_we = 1'b0; e_done = 1'b1;
                end else begin
                    m_idx++;
                    e_addr = 20'(32'(m_base) + 32'(m_idx));
                    e_data = m_words[m_idx];
                end
            end
        end
    end

    // Per-cycle compare against the model plus a write log for the directed literal checks.
    logic [19:0] q_addr [$];
    logic [11:0] q_data [$];
    int          n_busy = 0;
    int          n_done = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("we",   32'(bus.ram_we), 32'(e_we));
            chk("busy", 32'(bus.busy), 32'(e_we));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("addr", 32'(bus.ram_address), 32'(e_addr));
            chk("data", 32'(bus.ram_data), 32'(e_data));
            if (bus.ram_we === 1'b1) begin
                q_addr.push_back(bus.ram_address);
                q_data.push_back(bus.ram_data);
            end
            if (bus.busy === 1'b1) n_busy++;
            if (bus.done === 1'b1) n_done++;
        end
    end

    task automatic clear_log();
        q_addr.delete(); q_data.delete(); n_busy = 0; n_done = 0;
    endtask

    task automatic set_fields(input logic [11:0] id, input logic [19:0] off, input logic [11:0] ty,
                              input logic [9:0] x, input logic [9:0] y, input logic [11:0] sz,
                              input logic [11:0] rot);
        bus.id = id; bus.ram_address_offset = off; bus.ty = ty;
        bus.x = x; bus.y = y; bus.size = sz; bus.rotate = rot;
    endtask

    task automatic pulse_trigger();
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic check_addrs(input string nm, input logic [19:0] start);
        chk({nm, "_count"}, 32'(q_addr.size()), 32'd8);
        for (int i = 0; i < q_addr.size() && i < 8; i++)
            chk(nm, 32'(q_addr[i]), 32'(20'(32'(start) + i)));
    endtask

    logic [11:0] basic_data [8] = '{12'h001, 12'h155, 12'h0AA, 12'h040, 12'h003, 12'h000, 12'h000, 12'h000};
    logic [19:0] wrap_addr  [8] = '{20'hFFFFC, 20'hFFFFD, 20'hFFFFE, 20'hFFFFF,
                                    20'h00000, 20'h00001, 20'h00002, 20'h00003};

    initial begin
        rst_n = 1'b0;
        bus.trigger = 1'b0;
`ifdef SHAPE_WRITE_ERASE_EN
        bus.erase = 1'b0;
`endif
        set_fields('0, '0, '0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_we",   32'(bus.ram_we), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_addr", 32'(bus.ram_address), 32'd0);
        chk("rst_data", 32'(bus.ram_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic record
        clear_log();
        set_fields(12'd2, 20'h00100, 12'd1, 10'h155, 10'h0AA, 12'h040, 12'd3);
        pulse_trigger();
        wait_done("basic_done");
        @(negedge clk);
        check_addrs("basic_addr", 20'h00110);
        for (int i = 0; i < q_data.size() && i < 8; i++)
            chk("basic_data", 32'(q_data[i]), 32'(basic_data[i]));
        chk("basic_busy_cycles", 32'(n_busy), 32'd8);
        chk("basic_done_cycles", 32'(n_done), 32'd1);

        // Inputs changed right after the trigger must not leak into the record
        clear_log();
        set_fields(12'd3, 20'h00000, 12'h7A5, 10'h3C3, 10'h011, 12'h222, 12'h0F0);
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        set_fields(12'($urandom), 20'($urandom), 12'($urandom), 10'($urandom),
                   10'($urandom), 12'($urandom), 12'($urandom));
        wait_done("stab_done");
        check_addrs("stab_addr", 20'h00018);
        if (q_data.size() == 8) begin
            chk("stab_ty", 32'(q_data[0]), 32'h7A5);
            chk("stab_x",  32'(q_data[1]), 32'h3C3);
            chk("stab_rot", 32'(q_data[4]), 32'h0F0);
        end

        // Trigger while busy is dropped; trigger in the done cycle is taken
        clear_log();
        set_fields(12'd2, 20'h00100, 12'd9, 10'd1, 10'd2, 12'd3, 12'd4);
        pulse_trigger();
        repeat (4) @(negedge clk);
        bus.id = 12'd5;
        pulse_trigger();
        wait_done("busy_done");
        chk("busy_writes", 32'(q_addr.size()), 32'd8);
        clear_log();
        bus.id = 12'd5;
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        chk("b2b_start_we", 32'(bus.ram_we), 32'd1);
        chk("b2b_start_addr", 32'(bus.ram_address), 32'h00128);
        wait_done("b2b_done");
        check_addrs("b2b_addr", 20'h00128);

        // Address wrap
        clear_log();
        set_fields(12'd0, 20'hFFFFC, 12'd1, 10'd1, 10'd1, 12'd1, 12'd1);
        pulse_trigger();
        wait_done("wrap_done");
        chk("wrap_count", 32'(q_addr.size()), 32'd8);
        for (int i = 0; i < q_addr.size() && i < 8; i++)
            chk("wrap_addr", 32'(q_addr[i]), 32'(wrap_addr[i]));

        // Reset in the middle of a record
        @(negedge clk);
        clear_log();
        set_fields(12'd7, 20'h00000, 12'd1, 10'd1, 10'd1, 12'd1, 12'd1);
        pulse_trigger();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_we",   32'(bus.ram_we), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mrst_no_done", 32'(n_done), 32'd0);
        clear_log();
        set_fields(12'd4, 20'h00000, 12'd1, 10'd1, 10'd1, 12'd1, 12'd1);
        pulse_trigger();
        wait_done("mrst_restart_done");
        check_addrs("mrst_restart_addr", 20'h00020);

`ifdef SHAPE_WRITE_ERASE_EN
        // Erase writes a zero record
        clear_log();
        set_fields(12'd1, 20'h00000, 12'hABC, 10'h155, 10'h2AA, 12'h123, 12'h456);
        bus.erase = 1'b1;
        pulse_trigger();
        bus.erase = 1'b0;
        wait_done("erase_done");
        check_addrs("erase_addr", 20'h00008);
        for (int i = 0; i < q_data.size() && i < 8; i++)
            chk("erase_data", 32'(q_data[i]), 32'd0);
`endif

        // Random records, random trigger timing and lengths
        for (int n = 0; n < 60; n++) begin
            set_fields(12'($urandom), 20'($urandom), 12'($urandom), 10'($urandom),
                       10'($urandom), 12'($urandom), 12'($urandom));
`ifdef SHAPE_WRITE_ERASE_EN
            bus.erase = 1'($urandom);
`endif
            bus.trigger = 1'($urandom_range(0, 2) != 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bus.trigger = 1'b0;
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
